// File: rtl/dilator1.sv
// dilator1: streaming binary dilation over a raster, WIN_SIZE-1 line buffers plus raster resync FSM.
// Revision 1.0
`default_nettype none

module dilator1 #(
   parameter int H_IMG_RES = 640,
   parameter int V_IMG_RES = 480,
   parameter int WIN_SIZE  = 5,
   parameter logic [WIN_SIZE*WIN_SIZE-1:0] STRUCT_ELM = 25'b01110_11111_11111_11111_01110
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hpos,
   input  logic [10:0] vpos,
   input  logic        in_pix,
   output logic        out_pix,
   output logic [10:0] out_hpos,
   output logic [10:0] out_vpos,
   output logic        out_valid
);
   localparam int R     = WIN_SIZE / 2;
   localparam int NL    = WIN_SIZE - 1;
   localparam int COL_W = $clog2(H_IMG_RES);
   localparam int SEL_W = (NL > 1) ? $clog2(NL) : 1;
   localparam int SW1   = SEL_W + 1;

   localparam logic [10:0]      H_LAST   = 11'(H_IMG_RES - 1);
   localparam logic [10:0]      V_LAST   = 11'(V_IMG_RES - 1);
   localparam logic [10:0]      H_RES    = 11'(H_IMG_RES);
   localparam logic [10:0]      V_RES    = 11'(V_IMG_RES);
   localparam logic [10:0]      R_H      = 11'(R);
   localparam logic [10:0]      R_H1     = 11'(R + 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NL - 1);

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      FILL     = 2'd1,
      RUN      = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [H_IMG_RES-1:0] line_ram [NL];
   logic [SEL_W-1:0]     wr_sel;
   logic [WIN_SIZE-1:0]  win    [WIN_SIZE];
   logic [WIN_SIZE-1:0]  win_nx [WIN_SIZE];
   logic [10:0]          prev_h, prev_v, exp_h, exp_v;
   logic [10:0]          cx, cy, row_off;
   logic [SW1-1:0]       rd_sum;
   logic [COL_W-1:0]     col;
   logic                 contig, is_sof, at_prime, dil, tap_ok;

   assign col      = hpos[COL_W-1:0];
   assign is_sof   = (hpos == 11'd0) && (vpos == 11'd0);
   assign at_prime = (hpos == R_H) && (vpos == R_H);
   assign contig   = (hpos == exp_h) && (vpos == exp_v);

   // Line buffer contents are never reset; stale rows are masked by the centre bounds below.
   always_ff @(posedge clk) begin
      if (hpos < H_RES) begin
         line_ram[wr_sel][col] <= in_pix;
      end
   end

   always_comb begin
      exp_h = prev_h + 11'd1;
      exp_v = prev_v;
      if (prev_h == H_LAST) begin
         exp_h = 11'd0;
         exp_v = (prev_v == V_LAST) ? 11'd0 : prev_v + 11'd1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         WAIT_SOF: if (is_sof) state_nx = FILL;
         FILL: begin
            if (!contig)       state_nx = is_sof ? FILL : WAIT_SOF;
            else if (at_prime) state_nx = RUN;
         end
         RUN:     if (!contig) state_nx = is_sof ? FILL : WAIT_SOF;
         default: state_nx = WAIT_SOF;
      endcase
   end

   // Centre lags the input by R columns and R rows; columns left of R belong to the previous line.
   always_comb begin
      cx      = (hpos >= R_H) ? hpos - R_H : hpos + H_RES - R_H;
      row_off = (hpos >= R_H) ? R_H : R_H1;
      cy      = (vpos >= row_off) ? vpos - row_off : vpos + V_RES - row_off;
   end

   // Window bit c is the column dx = R - c (bit 0 newest); row r is dy = r - R.
   always_comb begin
      win_nx = win;
      rd_sum = '0;
      dil    = 1'b0;
      tap_ok = 1'b0;
      for (int r = 0; r < WIN_SIZE; r++) begin
         rd_sum = {1'b0, wr_sel} + SW1'(r);
         if (rd_sum >= SW1'(NL)) rd_sum = rd_sum - SW1'(NL);
         if (r == WIN_SIZE - 1) win_nx[r] = {win[r][WIN_SIZE-2:0], in_pix};
         else                   win_nx[r] = {win[r][WIN_SIZE-2:0], line_ram[rd_sum[SEL_W-1:0]][col]};
      end
      for (int r = 0; r < WIN_SIZE; r++) begin
         for (int c = 0; c < WIN_SIZE; c++) begin
            tap_ok = STRUCT_ELM[(WIN_SIZE-1-r)*WIN_SIZE + c];
            if (r < R) tap_ok = tap_ok && (cy >= 11'(R - r));
            if (r > R) tap_ok = tap_ok && (cy <= 11'(V_IMG_RES - 1 - (r - R)));
            if (c > R) tap_ok = tap_ok && (cx >= 11'(c - R));
            if (c < R) tap_ok = tap_ok && (cx <= 11'(H_IMG_RES - 1 - (R - c)));
            if (tap_ok) dil = dil | win_nx[r][c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= WAIT_SOF;
         wr_sel    <= '0;
         prev_h    <= '0;
         prev_v    <= '0;
         out_pix   <= 1'b0;
         out_hpos  <= '0;
         out_vpos  <= '0;
         out_valid <= 1'b0;
         for (int r = 0; r < WIN_SIZE; r++) win[r] <= '0;
      end else begin
         state  <= state_nx;
         win    <= win_nx;
         prev_h <= hpos;
         prev_v <= vpos;
         if (hpos == H_LAST) begin
            wr_sel <= (wr_sel == SEL_LAST) ? '0 : wr_sel + SEL_W'(1);
         end
         out_pix   <= dil;
         out_hpos  <= cx;
         out_vpos  <= cy;
         out_valid <= (state_nx == RUN);
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_dilator1.sv
// tb_dilator1: directed frame stream on a 16x8 raster with hand-computed probes and resync sequences.
// Revision 1.0
`default_nettype none

module tb_dilator1;
   localparam int H  = 16;
   localparam int V  = 8;
   localparam int NF = 11;

   logic        clk, rst_n, in_pix;
   logic [10:0] hpos, vpos;
   logic        out_pix, out_valid;
   logic [10:0] out_hpos, out_vpos;

   dilator1 #(.H_IMG_RES(H), .V_IMG_RES(V), .WIN_SIZE(5),
              .STRUCT_ELM(25'b01110_11111_11111_11111_01110)) dut (
      .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .in_pix(in_pix),
      .out_pix(out_pix), .out_hpos(out_hpos), .out_vpos(out_vpos), .out_valid(out_valid)
   );

   typedef struct { int pat; int px; int py; int ones; } frame_t;
   typedef struct { int fid; int cx; int cy; int exp; } probe_t;

   frame_t   frames [NF];
   probe_t   probes [40];
   int       np = 0;
   bit [4:0] se_rows [5] = '{5'b01110, 5'b11111, 5'b11111, 5'b11111, 5'b01110};
   bit       img [NF][V][H];
   bit       cap [NF][V][H];
   int       capn [NF];
   bit       done [NF];
   int       fstart [NF];
   int       checks = 0, errors = 0;
   int       cyc = 0, cur_fid = 0, out_fid = -1;
   int       seen_cyc = -1, seen_h = -1, seen_v = -1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic set_frame(input int f, input int pat, input int px, input int py, input int ones);
      frames[f] = '{pat, px, py, ones};
   endtask

   task automatic add_probe(input int f, input int x, input int y, input int e);
      probes[np] = '{f, x, y, e};
      np++;
   endtask

   function automatic bit gen_pix(input int f, input int x, input int y);
      case (frames[f].pat)
         1:       return 1'b1;
         2:       return (x == frames[f].px) && (y == frames[f].py);
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit ref_pix(input int f, input int cx, input int cy);
      bit acc = 1'b0;
      for (int dy = -2; dy <= 2; dy++)
         for (int dx = -2; dx <= 2; dx++)
            if (se_rows[dy+2][2-dx] && cx+dx >= 0 && cx+dx < H && cy+dy >= 0 && cy+dy < V)
               acc = acc | img[f][cy+dy][cx+dx];
      return acc;
   endfunction

   task automatic arm();
      seen_cyc = -1;
      seen_h   = -1;
      seen_v   = -1;
   endtask

   task automatic monitor();
      int oh, ov;
      oh = int'(out_hpos);
      ov = int'(out_vpos);
      if (out_valid && seen_cyc < 0) begin
         seen_cyc = cyc + 1;
         seen_h   = oh;
         seen_v   = ov;
      end
      if (out_valid) begin
         if (oh == 0 && ov == 0) begin
            out_fid       = cur_fid;
            capn[out_fid] = 0;
            done[out_fid] = 1'b0;
         end
         if (out_fid >= 0 && oh < H && ov < V) begin
            cap[out_fid][ov][oh] = out_pix;
            capn[out_fid]++;
            if (oh == H-1 && ov == V-1) done[out_fid] = 1'b1;
         end
      end
   endtask

   task automatic drive(input int h, input int v, input bit p);
      hpos   = 11'(h);
      vpos   = 11'(v);
      in_pix = p;
      @(posedge clk);
      #1;
      monitor();
      cyc++;
   endtask

   task automatic run_frame(input int f);
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            img[f][y][x] = gen_pix(f, x, y);
            if (f == 6 && y == 5 && x == 6) continue;
            drive(x, y, img[f][y][x]);
            if (f == 6 && y == 5 && x == 5) chk("pre_disc_valid", int'(out_valid), 1);
            if (f == 6 && y == 5 && x == 7) begin
               chk("disc_valid_drop", int'(out_valid), 0);
               arm();
            end
            if (f == 8 && y == 5 && x == 9) begin
               chk("pre_reset_valid", int'(out_valid), 1);
               #2 rst_n = 1'b0;
               #1;
               chk("async_reset_valid", int'(out_valid), 0);
               chk("async_reset_pix_hv", int'({out_pix, out_hpos, out_vpos}), 0);
               repeat (2) @(posedge clk);
               #1 rst_n = 1'b1;
               arm();
            end
         end
      end
   endtask

   initial begin
      int mism, ones;
      set_frame(0, 0, 0, 0, 0);
      set_frame(1, 2, 8, 4, 21);
      set_frame(2, 2, 0, 0, 8);
      set_frame(3, 1, 0, 0, 128);
      set_frame(4, 0, 0, 0, 0);
      set_frame(5, 2, 15, 3, 13);
      set_frame(6, 0, 0, 0, -1);
      set_frame(7, 2, 15, 7, 8);
      set_frame(8, 0, 0, 0, -1);
      set_frame(9, 2, 8, 4, 21);
      set_frame(10, 0, 0, 0, -1);
      add_probe(1, 8, 4, 1);  add_probe(1, 7, 2, 1);  add_probe(1, 6, 2, 0);
      add_probe(1, 10, 4, 1); add_probe(1, 11, 4, 0); add_probe(1, 8, 7, 0);
      add_probe(1, 8, 1, 0);
      add_probe(2, 2, 1, 1);  add_probe(2, 2, 2, 0);  add_probe(2, 1, 2, 1);
      add_probe(2, 15, 0, 0); add_probe(2, 14, 1, 0); add_probe(2, 0, 7, 0);
      add_probe(2, 0, 6, 0);
      add_probe(3, 0, 0, 1);  add_probe(3, 15, 0, 1); add_probe(3, 0, 7, 1);
      add_probe(3, 15, 7, 1);
      add_probe(4, 0, 0, 0);  add_probe(4, 15, 7, 0);
      add_probe(5, 0, 3, 0);  add_probe(5, 0, 4, 0);  add_probe(5, 13, 3, 1);
      add_probe(5, 13, 1, 0); add_probe(5, 15, 5, 1);
      add_probe(7, 13, 6, 1); add_probe(7, 15, 5, 1); add_probe(7, 13, 5, 0);
      add_probe(7, 0, 0, 0);
      add_probe(9, 8, 4, 1);  add_probe(9, 6, 2, 0);

      rst_n = 1'b0; hpos = '0; vpos = '0; in_pix = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", int'({out_valid, out_pix, out_hpos, out_vpos}), 0);
      rst_n = 1'b1;
      arm();

      for (int f = 0; f < NF; f++) begin
         fstart[f] = cyc;
         cur_fid   = f;
         run_frame(f);
         if (f == 0 || f == 7 || f == 9) begin
            chk($sformatf("first_valid_cycle_f%0d", f), seen_cyc, fstart[f] + 35);
            chk($sformatf("first_valid_hpos_f%0d", f), seen_h, 0);
            chk($sformatf("first_valid_vpos_f%0d", f), seen_v, 0);
         end
      end

      for (int f = 0; f < NF; f++) begin
         if (frames[f].ones < 0) continue;
         chk($sformatf("frame%0d_complete", f), done[f] ? capn[f] : -1, H*V);
         mism = 0;
         ones = 0;
         for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
               if (cap[f][y][x] != ref_pix(f, x, y)) mism++;
               if (cap[f][y][x]) ones++;
            end
         chk($sformatf("frame%0d_model_mismatches", f), mism, 0);
         chk($sformatf("frame%0d_ones", f), ones, frames[f].ones);
      end

      for (int i = 0; i < np; i++)
         chk($sformatf("probe_f%0d_(%0d,%0d)", probes[i].fid, probes[i].cx, probes[i].cy),
             int'(cap[probes[i].fid][probes[i].cy][probes[i].cx]), probes[i].exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
